// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg
// Shared definitions for the LDM/STM multi-register transfer sequencer:
//   - state_t : sequencer state encoding (ST_ABORT exists only when
//               MOC_TIMEOUT_EN is defined)
//   - IR_*    : bit positions of the addressing-mode-4 instruction fields
//   - mode_t  : addressing modes, encoded as {P, U}
package ldm_stm_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ADDR,
      ST_XFER,
      ST_LDWR,
      ST_NEXT,
      ST_WB,
      ST_DONE
`ifdef MOC_TIMEOUT_EN
      , ST_ABORT
`endif
   } state_t;

   localparam int IR_P     = 24;
   localparam int IR_U     = 23;
   localparam int IR_S     = 22;
   localparam int IR_W     = 21;
   localparam int IR_L     = 20;
   localparam int IR_RN_HI = 19;
   localparam int IR_RN_LO = 16;

   // {P, U}: P = pre-index, U = increment
   typedef enum logic [1:0] {
      MODE_DA = 2'b00,
      MODE_IA = 2'b01,
      MODE_DB = 2'b10,
      MODE_IB = 2'b11
   } mode_t;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// reg_list_scan
// Combinational scan of a register list.
//   list  in  NREG  register list (bit i = register i)
//   idx   out 4     index of the lowest set bit (0 when list is empty)
//   none  out 1     list is empty
//   count out 5     number of set bits
module reg_list_scan #(
   parameter int NREG = 16
) (
   input  logic [NREG-1:0] list,
   output logic [3:0]      idx,
   output logic            none,
   output logic [4:0]      count
);

   always_comb begin
      idx   = '0;
      count = '0;
      // Walk downwards so the last hit written is the lowest set bit.
      for (int i = NREG - 1; i >= 0; i--) begin
         if (list[i]) begin
            idx = 4'(i);
         end
      end
      for (int i = 0; i < NREG; i++) begin
         count = count + 5'(list[i]);
      end
   end

   assign none = ~|list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Multi-register transfer sequencer for ARM addressing mode 4 (LDM/STM).
// On start it latches the instruction fields and base, walks the register
// list lowest-first issuing one mov/moc memory transfer per register, then
// optionally writes back the base register and pulses done.
//
// Optional feature: define MOC_TIMEOUT_EN to add a watchdog that aborts a
// transfer after TO_CYCLES XFER cycles without moc.
//
// Ports:
//   clk     in   system clock (rising edge)
//   clr     in   asynchronous active-high reset
//   start   in   one-cycle request, sampled in IDLE only
//   ir      in   mode-4 instruction word
//   base    in   current value of Rn, sampled with start
//   moc     in   memory operation complete
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse on normal completion
//   abort   out  one-cycle pulse on watchdog expiry (0 without the watchdog)
//   addr    out  address for MAR (valid with mar_ld)
//   mar_ld  out  MAR load strobe
//   mdr_ld  out  MDR load strobe
//   r_w     out  1 = read (LDM), 0 = write (STM), valid during mov
//   mov     out  memory request strobe
//   rf_sel  out  register-file select
//   rf_ld   out  register-file write strobe
//   wb_val  out  base writeback value
//   wb_ld   out  base writeback strobe (target Rn)
module ldm_stm_sequencer
   import ldm_stm_sequencer_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int NREG       = 16,
   parameter int WORD_BYTES = 4,
   parameter int TO_CYCLES  = 255
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [31:0]       ir,
   input  logic [ADDR_W-1:0] base,
   input  logic              moc,
   output logic              busy,
   output logic              done,
   output logic              abort,
   output logic [ADDR_W-1:0] addr,
   output logic              mar_ld,
   output logic              mdr_ld,
   output logic              r_w,
   output logic              mov,
   output logic [3:0]        rf_sel,
   output logic              rf_ld,
   output logic [ADDR_W-1:0] wb_val,
   output logic              wb_ld
);

   state_t            state_reg, state_next;

   logic              p_reg, u_reg, w_reg, l_reg;
   logic [3:0]        rn_reg;
   logic [NREG-1:0]   list_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] wb_val_reg;

   logic [3:0]        scan_idx;
   logic              scan_none;
   logic [4:0]        scan_cnt;

   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] setup_addr;
   logic [NREG-1:0]   cur_onehot;
   logic [NREG-1:0]   list_left;
   mode_t             mode;

   // Bits of ir that carry nothing for this block (S is deliberately ignored).
   logic              unused_ir;
   assign unused_ir = ^{ir[31:25], ir[IR_S], ir[15:0]};

   reg_list_scan #(
      .NREG (NREG)
   ) u_scan (
      .list  (list_reg),
      .idx   (scan_idx),
      .none  (scan_none),
      .count (scan_cnt)
   );

   assign span       = ADDR_W'(scan_cnt) * ADDR_W'(WORD_BYTES);
   assign mode       = mode_t'({p_reg, u_reg});
   assign cur_onehot = NREG'(1) << scan_idx;
   assign list_left  = list_reg & ~cur_onehot;

   // Lowest address touched; transfers always ascend from here.
   always_comb begin
      setup_addr = base_reg;
      case (mode)
         MODE_IA: setup_addr = base_reg;
         MODE_IB: setup_addr = base_reg + ADDR_W'(WORD_BYTES);
         MODE_DA: setup_addr = base_reg - span + ADDR_W'(WORD_BYTES);
         MODE_DB: setup_addr = base_reg - span;
         default: setup_addr = base_reg;
      endcase
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         p_reg      <= 1'b0;
         u_reg      <= 1'b0;
         w_reg      <= 1'b0;
         l_reg      <= 1'b0;
         rn_reg     <= '0;
         list_reg   <= '0;
         base_reg   <= '0;
         addr_reg   <= '0;
         wb_val_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  p_reg    <= ir[IR_P];
                  u_reg    <= ir[IR_U];
                  w_reg    <= ir[IR_W];
                  l_reg    <= ir[IR_L];
                  rn_reg   <= ir[IR_RN_HI:IR_RN_LO];
                  list_reg <= ir[NREG-1:0];
                  base_reg <= base;
               end
            end
            ST_SETUP: begin
               addr_reg   <= setup_addr;
               // span is zero for an empty list, so this yields base then.
               wb_val_reg <= u_reg ? (base_reg + span) : (base_reg - span);
            end
            ST_NEXT: begin
               addr_reg <= addr_reg + ADDR_W'(WORD_BYTES);
               list_reg <= list_left;
            end
            default: ;
         endcase
      end
   end

`ifdef MOC_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_reg;
   logic            to_expire;

   // Cleared in ADDR, which is the only way into XFER.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         to_cnt_reg <= '0;
      end else if (state_reg == ST_ADDR) begin
         to_cnt_reg <= '0;
      end else if (state_reg == ST_XFER && !moc) begin
         to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
   end

   // True on the XFER cycle whose missing moc brings the count to TO_CYCLES.
   assign to_expire = (to_cnt_reg == TO_W'(TO_CYCLES - 1));
`else
   localparam int unused_to_cycles = TO_CYCLES;
`endif

   // ------------------------------------------------------------ next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start) state_next = ST_SETUP;
         ST_SETUP: begin
            if (scan_none) begin
               state_next = w_reg ? ST_WB : ST_DONE;
            end else begin
               state_next = ST_ADDR;
            end
         end
         ST_ADDR:  state_next = ST_XFER;
         ST_XFER: begin
            if (moc) begin
               state_next = l_reg ? ST_LDWR : ST_NEXT;
            end
`ifdef MOC_TIMEOUT_EN
            else if (to_expire) begin
               state_next = ST_ABORT;
            end
`endif
         end
         ST_LDWR:  state_next = ST_NEXT;
         ST_NEXT: begin
            if (|list_left) begin
               state_next = ST_ADDR;
            end else begin
               state_next = w_reg ? ST_WB : ST_DONE;
            end
         end
         ST_WB:    state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
`ifdef MOC_TIMEOUT_EN
         ST_ABORT: state_next = ST_IDLE;
`endif
         default:  state_next = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      busy   = (state_reg != ST_IDLE);
      done   = 1'b0;
      addr   = '0;
      mar_ld = 1'b0;
      mdr_ld = 1'b0;
      r_w    = 1'b0;
      mov    = 1'b0;
      rf_sel = '0;
      rf_ld  = 1'b0;
      wb_ld  = 1'b0;
      case (state_reg)
         ST_ADDR: begin
            mar_ld = 1'b1;
            addr   = addr_reg;
            rf_sel = scan_idx;
            mdr_ld = ~l_reg;           // STM: capture register data now
         end
         ST_XFER: begin
            mov    = 1'b1;
            r_w    = l_reg;
            mdr_ld = l_reg & moc;      // LDM: capture memory data on completion
         end
         ST_LDWR: begin
            rf_ld  = 1'b1;
            rf_sel = scan_idx;
         end
         ST_WB: begin
            wb_ld  = 1'b1;
            rf_sel = rn_reg;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

`ifdef MOC_TIMEOUT_EN
   assign abort = (state_reg == ST_ABORT);
`else
   assign abort = 1'b0;
`endif

   assign wb_val = wb_val_reg;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer
// Self-checking bench for ldm_stm_sequencer. A transaction-level model turns
// the instruction fields, base and per-transfer moc delays into the expected
// cycle-by-cycle output trace; the bench replays the trace's inputs and
// compares every output on every cycle. Directed scenarios pin the model
// with hand-computed values. Define MOC_TIMEOUT_EN to exercise the watchdog.
module tb_ldm_stm_sequencer;

   localparam int TB_TO = 8;
`ifdef MOC_TIMEOUT_EN
   localparam int TO_LIM = TB_TO;
`else
   localparam int TO_LIM = 0;
`endif

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic [31:0] ir = '0;
   logic [31:0] base = '0;
   logic        moc = 1'b0;
   logic        busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld;
   logic [31:0] addr, wb_val;
   logic [3:0]  rf_sel;

   always #5 clk = ~clk;

   ldm_stm_sequencer #(
      .ADDR_W     (32),
      .NREG       (16),
      .WORD_BYTES (4),
      .TO_CYCLES  (TB_TO)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .ir     (ir),
      .base   (base),
      .moc    (moc),
      .busy   (busy),
      .done   (done),
      .abort  (abort),
      .addr   (addr),
      .mar_ld (mar_ld),
      .mdr_ld (mdr_ld),
      .r_w    (r_w),
      .mov    (mov),
      .rf_sel (rf_sel),
      .rf_ld  (rf_ld),
      .wb_val (wb_val),
      .wb_ld  (wb_ld)
   );

   typedef struct {
      logic        start, moc;
      logic        busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld;
      logic [31:0] addr;
      logic [3:0]  rf_sel;
   } cyc_t;

   cyc_t        trace[$];
   int          waits[16];
   logic [31:0] exp_wb_val;

   int          n_tests = 0;
   int          n_fail  = 0;

   int          obs_done, obs_abort, obs_mov, obs_wb;
   logic [31:0] obs_addr[$];
   int          obs_rf[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic cyc_t blank(input logic bsy);
      cyc_t c;
      c.start = 1'b0; c.moc = 1'($urandom_range(0, 1));
      c.busy = bsy; c.done = 1'b0; c.abort = 1'b0; c.mar_ld = 1'b0;
      c.mdr_ld = 1'b0; c.r_w = 1'b0; c.mov = 1'b0; c.rf_ld = 1'b0;
      c.wb_ld = 1'b0; c.addr = '0; c.rf_sel = '0;
      return c;
   endfunction

   function automatic logic [44:0] pack(input cyc_t c);
      return {c.busy, c.done, c.abort, c.mar_ld, c.mdr_ld, c.r_w, c.mov,
              c.rf_ld, c.wb_ld, c.rf_sel, c.addr};
   endfunction

   function automatic logic [31:0] mk_ir(input logic p, u, w, l, input logic [3:0] rn,
                                         input logic [15:0] list);
      return {7'($urandom), p, u, 1'($urandom), w, l, rn, list};
   endfunction

   task automatic set_waits(input int v);
      for (int i = 0; i < 16; i++) waits[i] = v;
   endtask

   // Expected trace: record 0 is the IDLE cycle carrying start, then one
   // record per sequencer cycle, ending with one IDLE cycle.
   task automatic build_trace(input logic p, u, w, l, input logic [3:0] rn,
                              input logic [15:0] list, input logic [31:0] b,
                              input int to_lim);
      cyc_t        c;
      int          cnt, k, nz;
      logic [31:0] span, lowest;
      trace.delete();
      cnt        = $countones(list);
      span       = 32'(cnt * 4);
      lowest     = u ? (p ? b + 32'd4 : b) : (p ? b - span : b - span + 32'd4);
      exp_wb_val = u ? b + span : b - span;
      c = blank(1'b0); c.start = 1'b1; trace.push_back(c);
      c = blank(1'b1); trace.push_back(c);                       // SETUP
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            c = blank(1'b1); c.mar_ld = 1'b1; c.addr = lowest + 32'(k * 4);
            c.rf_sel = 4'(i); c.mdr_ld = ~l; trace.push_back(c);
            nz = waits[k];
            if (to_lim > 0 && nz > to_lim) nz = to_lim;
            for (int j = 0; j < nz; j++) begin
               c = blank(1'b1); c.moc = 1'b0; c.mov = 1'b1; c.r_w = l;
               trace.push_back(c);
            end
            if (to_lim > 0 && nz == to_lim) begin
               c = blank(1'b1); c.abort = 1'b1; trace.push_back(c);
               c = blank(1'b0); trace.push_back(c);
               return;
            end
            c = blank(1'b1); c.moc = 1'b1; c.mov = 1'b1; c.r_w = l; c.mdr_ld = l;
            trace.push_back(c);
            if (l) begin
               c = blank(1'b1); c.rf_ld = 1'b1; c.rf_sel = 4'(i); trace.push_back(c);
            end
            c = blank(1'b1); trace.push_back(c);                 // NEXT
            k++;
         end
      end
      if (w) begin
         c = blank(1'b1); c.wb_ld = 1'b1; c.rf_sel = rn; trace.push_back(c);
      end
      c = blank(1'b1); c.done = 1'b1; trace.push_back(c);
      c = blank(1'b0); trace.push_back(c);
   endtask

   // Replays the trace; start/ir/base are scrambled while busy to show they
   // are ignored, moc outside XFER is random.
   task automatic run_txn(input string tag, input logic [31:0] ir_v, input logic [31:0] base_v);
      logic [44:0] act;
      obs_done = -1; obs_abort = -1; obs_mov = 0; obs_wb = 0;
      obs_addr.delete(); obs_rf.delete();
      for (int k = 0; k < trace.size(); k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            start = 1'b1; ir = ir_v; base = base_v;
         end else if (trace[k].busy) begin
            start = 1'($urandom_range(0, 1)); ir = $urandom; base = $urandom;
         end else begin
            start = 1'b0;
         end
         moc = trace[k].moc;
         @(negedge clk);
         act = {busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld, rf_sel, addr};
         check($sformatf("%s cyc%0d", tag, k), 64'(act), 64'(pack(trace[k])));
         if (trace[k].wb_ld) check($sformatf("%s wb_val", tag), 64'(wb_val), 64'(exp_wb_val));
         if (done) obs_done = k;
         if (abort) obs_abort = k;
         if (mov) obs_mov++;
         if (wb_ld) obs_wb++;
         if (mar_ld) obs_addr.push_back(addr);
         if (rf_ld) obs_rf.push_back(int'(rf_sel));
      end
      start = 1'b0;
      $display("[TB] txn %s ir=%h base=%h cycles=%0d done@%0d", tag, ir_v, base_v,
               trace.size(), obs_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [44:0] act;
      logic [31:0] irv, bv;
      logic        p, u, w, l;
      logic [3:0]  rn;
      logic [15:0] list;

      // ---- reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      act = {busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld, rf_sel, addr};
      check("reset outputs", 64'(act), 64'd0);
      check("reset wb_val", 64'(wb_val), 64'd0);
      clr = 1'b0;
      @(negedge clk);
      check("post-reset busy", 64'(busy), 64'd0);

      // ---- STMIA base 0x100 list 0x000B W=1
      set_waits(0);
      build_trace(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h000B, 32'h100, TO_LIM);
      check("model stmia len", 64'(trace.size()), 64'd14);
      check("model stmia done", 64'(trace[12].done), 64'd1);
      check("model stmia wb_val", 64'(exp_wb_val), 64'h10C);
      check("model stmia rf_sel", 64'({trace[2].rf_sel, trace[5].rf_sel, trace[8].rf_sel}),
            64'({4'd0, 4'd1, 4'd3}));
      run_txn("stmia", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h000B), 32'h100);
      check("stmia done cycle", 64'(obs_done), 64'd12);
      check("stmia addr count", 64'(obs_addr.size()), 64'd3);
      check("stmia addrs", {obs_addr[0][15:0], obs_addr[1][15:0], obs_addr[2][15:0], 16'h0},
            {16'h100, 16'h104, 16'h108, 16'h0});
      check("stmia wb_ld count", 64'(obs_wb), 64'd1);

      // ---- LDMDB base 0x200 list 0x8001 W=0
      build_trace(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 16'h8001, 32'h200, TO_LIM);
      run_txn("ldmdb", mk_ir(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 16'h8001), 32'h200);
      check("ldmdb addr count", 64'(obs_addr.size()), 64'd2);
      check("ldmdb addrs", {obs_addr[0], obs_addr[1]}, {32'h1F8, 32'h1FC});
      check("ldmdb rf_ld regs", {32'(obs_rf.size()), 16'(obs_rf[0]), 16'(obs_rf[1])},
            {32'd2, 16'd0, 16'd15});
      check("ldmdb no wb_ld", 64'(obs_wb), 64'd0);

      // ---- LDMIB list 0x0004, zero wait then 5-cycle moc delay
      build_trace(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0004, 32'h300, TO_LIM);
      run_txn("ldmib w0", mk_ir(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0004), 32'h300);
      check("ldmib w0 done cycle", 64'(obs_done), 64'd6);
      set_waits(5);
      build_trace(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0004, 32'h300, TO_LIM);
      run_txn("ldmib w5", mk_ir(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0004), 32'h300);
      check("ldmib w5 done cycle", 64'(obs_done), 64'd11);
      check("ldmib w5 mov cycles", 64'(obs_mov), 64'd6);
      check("ldmib w5 addr", 64'(obs_addr[0]), 64'h304);
      set_waits(0);

      // ---- empty list, W=1, base 0x40
      build_trace(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0000, 32'h40, TO_LIM);
      check("model empty wb_val", 64'(exp_wb_val), 64'h40);
      run_txn("empty", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0000), 32'h40);
      check("empty done cycle", 64'(obs_done), 64'd3);
      check("empty no mov", 64'(obs_mov), 64'd0);
      check("empty wb_ld count", 64'(obs_wb), 64'd1);

      // ---- asynchronous clr during XFER
      @(posedge clk); #1;
      start = 1'b1; moc = 1'b0; base = 32'h500;
      ir = mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h00F0);
      @(posedge clk); #1; start = 1'b0;              // SETUP
      @(posedge clk);                                // ADDR
      @(posedge clk); #1;                            // XFER
      check("pre-clr mov", 64'(mov), 64'd1);
      #2 clr = 1'b1;
      #1;
      act = {busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld, rf_sel, addr};
      check("async clr outputs", 64'(act), 64'd0);
      check("async clr wb_val", 64'(wb_val), 64'd0);
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      act = {busy, done, abort, mar_ld, mdr_ld, r_w, mov, rf_ld, wb_ld, rf_sel, addr};
      check("post-clr idle", 64'(act), 64'd0);
      build_trace(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h000B, 32'h100, TO_LIM);
      run_txn("after clr", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h000B), 32'h100);
      check("after clr done cycle", 64'(obs_done), 64'd12);

`ifdef MOC_TIMEOUT_EN
      // ---- watchdog: moc never arrives
      set_waits(100);
      build_trace(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0003, 32'h80, TO_LIM);
      check("model abort len", 64'(trace.size()), 64'd13);
      run_txn("timeout", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0003), 32'h80);
      check("timeout abort cycle", 64'(obs_abort), 64'd11);
      check("timeout mov cycles", 64'(obs_mov), 64'd8);
      check("timeout no wb_ld", 64'(obs_wb), 64'd0);
      check("timeout no done", 64'(obs_done), 64'hFFFF_FFFF_FFFF_FFFF);
      set_waits(0);
`endif

      // ---- randomized transactions
      for (int t = 0; t < 40; t++) begin
         p  = 1'($urandom); u = 1'($urandom); w = 1'($urandom); l = 1'($urandom);
         rn = 4'($urandom);
         case ($urandom_range(0, 3))
            0:       list = 16'h0000;
            1:       list = 16'(1 << $urandom_range(0, 15));
            2:       list = 16'($urandom) & 16'($urandom);
            default: list = 16'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0:       bv = 32'($urandom_range(0, 32)) & ~32'd3;   // wraps below zero
            1:       bv = 32'hFFFF_FFF0;                        // wraps above top
            default: bv = $urandom & ~32'd3;
         endcase
         for (int i = 0; i < 16; i++) waits[i] = $urandom_range(0, 3);
         build_trace(p, u, w, l, rn, list, bv, TO_LIM);
         irv = mk_ir(p, u, w, l, rn, list);
         run_txn($sformatf("rand%0d", t), irv, bv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
